// File: rtl/result_checker.sv
// result_checker: response-side checker for the circuit1 datapath.
// Expected results travel through a LATENCY-deep pipeline alongside the
// DUT and are compared against dut_z / dut_x when they emerge. Pass and fail
// counts saturate, err is sticky per run, and the index of the first
// mismatching vector is latched.
//
// Optional build macro: RESULT_CHECKER_CAPTURE_EN
//   defined   : fail_z / fail_x hold the DUT values seen at the first mismatch
//   undefined : no capture registers; fail_z / fail_x are tied to 0
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start after reset
// S_RUN   | accepting vectors until the one marked stim_last
// S_DRAIN | no new vectors; waiting for the last entry to reach the tail
// S_DONE  | run complete; start begins a fresh run

module result_checker #(
    parameter int DATAW   = 8,
    parameter int PRODW   = 16,
    parameter int LATENCY = 1,
    parameter int CNTW    = 16
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    start,
    input  logic                    stim_valid,
    input  logic                    stim_last,
    input  logic signed [DATAW-1:0] exp_z,
    input  logic signed [PRODW-1:0] exp_x,
    input  logic signed [DATAW-1:0] dut_z,
    input  logic signed [PRODW-1:0] dut_x,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [CNTW-1:0]         pass_cnt,
    output logic [CNTW-1:0]         fail_cnt,
    output logic [CNTW-1:0]         first_fail_idx,
    output logic signed [DATAW-1:0] fail_z,
    output logic signed [PRODW-1:0] fail_x
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // DRAIN lasts LATENCY-1 cycles; the timer counts down to zero.
    localparam logic [3:0] DRAIN_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t state, state_nxt;
    logic   clear_run;
    logic   accept;

    logic [3:0] drain_cnt;

    logic                    pipe_v   [LATENCY];
    logic signed [DATAW-1:0] pipe_z   [LATENCY];
    logic signed [PRODW-1:0] pipe_x   [LATENCY];
    logic [CNTW-1:0]         pipe_idx [LATENCY];

    logic [CNTW-1:0] vec_idx;

    logic tail_v;
    logic tail_match;
    logic first_fail;

    assign tail_v     = pipe_v[LATENCY-1];
    assign tail_match = (pipe_z[LATENCY-1] == dut_z) && (pipe_x[LATENCY-1] == dut_x);
    assign first_fail = tail_v && !tail_match && !err;

    // State register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode, run clear and vector acceptance.
    always_comb begin
        state_nxt = state;
        clear_run = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    clear_run = 1'b1;
                end
            end
            S_RUN: begin
                if (stim_valid) begin
                    accept = 1'b1;
                    if (stim_last) begin
                        state_nxt = (LATENCY == 1) ? S_DONE : S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt == 4'd0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    clear_run = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Drain timer: loaded on the final vector, counts down while draining.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            drain_cnt <= 4'd0;
        end else if (accept && stim_last) begin
            drain_cnt <= DRAIN_LOAD;
        end else if (state == S_DRAIN && drain_cnt != 4'd0) begin
            drain_cnt <= drain_cnt - 4'd1;
        end
    end

    // Vector index of the next accepted vector; wraps naturally.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            vec_idx <= '0;
        end else if (clear_run) begin
            vec_idx <= '0;
        end else if (accept) begin
            vec_idx <= vec_idx + CNTW'(1);
        end
    end

    // Expected-result pipeline; shifts every cycle so bubbles travel too.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_v[i]   <= 1'b0;
                pipe_z[i]   <= '0;
                pipe_x[i]   <= '0;
                pipe_idx[i] <= '0;
            end
        end else begin
            pipe_v[0]   <= accept;
            pipe_z[0]   <= exp_z;
            pipe_x[0]   <= exp_x;
            pipe_idx[0] <= vec_idx;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_z[i]   <= pipe_z[i-1];
                pipe_x[i]   <= pipe_x[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
            // A new run discards anything still in flight from the previous one.
            if (clear_run) begin
                for (int i = 0; i < LATENCY; i++) begin
                    pipe_v[i] <= 1'b0;
                end
            end
        end
    end

    // Result bookkeeping at the pipeline tail.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            err            <= 1'b0;
            first_fail_idx <= '1;
        end else if (clear_run) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            err            <= 1'b0;
            first_fail_idx <= '1;
        end else if (tail_v) begin
            if (tail_match) begin
                if (pass_cnt != '1) begin
                    pass_cnt <= pass_cnt + CNTW'(1);
                end
            end else begin
                if (fail_cnt != '1) begin
                    fail_cnt <= fail_cnt + CNTW'(1);
                end
                err <= 1'b1;
                if (!err) begin
                    first_fail_idx <= pipe_idx[LATENCY-1];
                end
            end
        end
    end

`ifdef RESULT_CHECKER_CAPTURE_EN
    // Capture the DUT values seen at the first mismatch of the run.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            fail_z <= '0;
            fail_x <= '0;
        end else if (clear_run) begin
            fail_z <= '0;
            fail_x <= '0;
        end else if (first_fail) begin
            fail_z <= dut_z;
            fail_x <= dut_x;
        end
    end
`else
    assign fail_z = '0;
    assign fail_x = '0;
`endif

    // Registered status flags follow the next state.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
            done <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_result_checker.sv
// Bench for result_checker: three instances (LATENCY=1, LATENCY=3, and a
// 2-bit-counter LATENCY=1 copy for saturation/wrap) share one stimulus
// stream. Responses are replayed to each instance after its latency; a
// scoreboard queue per latency predicts the counts.

module tb_result_checker;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic               Rst, start, stim_valid, stim_last;
    logic signed [7:0]  exp_z, dut_z1, dut_z3;
    logic signed [15:0] exp_x, dut_x1, dut_x3;

    logic               busy1, done1, err1, busy3, done3, err3, busys, dones, errs;
    logic [15:0]        pass1, fail1, ffi1, pass3, fail3, ffi3;
    logic [1:0]         passs, fails, ffis;
    logic signed [7:0]  fz1, fz3, fzs;
    logic signed [15:0] fx1, fx3, fxs;

`ifdef RESULT_CHECKER_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    result_checker #(.DATAW(8), .PRODW(16), .LATENCY(1), .CNTW(16)) u_l1 (
        .Clk(Clk), .Rst(Rst), .start(start), .stim_valid(stim_valid), .stim_last(stim_last),
        .exp_z(exp_z), .exp_x(exp_x), .dut_z(dut_z1), .dut_x(dut_x1),
        .busy(busy1), .done(done1), .err(err1), .pass_cnt(pass1), .fail_cnt(fail1),
        .first_fail_idx(ffi1), .fail_z(fz1), .fail_x(fx1));

    result_checker #(.DATAW(8), .PRODW(16), .LATENCY(3), .CNTW(16)) u_l3 (
        .Clk(Clk), .Rst(Rst), .start(start), .stim_valid(stim_valid), .stim_last(stim_last),
        .exp_z(exp_z), .exp_x(exp_x), .dut_z(dut_z3), .dut_x(dut_x3),
        .busy(busy3), .done(done3), .err(err3), .pass_cnt(pass3), .fail_cnt(fail3),
        .first_fail_idx(ffi3), .fail_z(fz3), .fail_x(fx3));

    result_checker #(.DATAW(8), .PRODW(16), .LATENCY(1), .CNTW(2)) u_sat (
        .Clk(Clk), .Rst(Rst), .start(start), .stim_valid(stim_valid), .stim_last(stim_last),
        .exp_z(exp_z), .exp_x(exp_x), .dut_z(dut_z1), .dut_x(dut_x1),
        .busy(busys), .done(dones), .err(errs), .pass_cnt(passs), .fail_cnt(fails),
        .first_fail_idx(ffis), .fail_z(fzs), .fail_x(fxs));

    typedef struct {
        int                 stepn;
        int                 idx;
        logic signed [7:0]  ez, rz;
        logic signed [15:0] ex, rx;
    } sb_t;

    sb_t                sb_q [2][$];
    int                 m_pass [2];
    int                 m_fail [2];
    bit                 m_err  [2];
    logic [15:0]        m_ffi  [2];
    logic signed [7:0]  m_fz   [2];
    logic signed [15:0] m_fx   [2];
    int                 m_idx;
    bit                 running;
    int                 cur_step;

    logic signed [7:0]  hz [4];
    logic signed [15:0] hx [4];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_reset();
        for (int li = 0; li < 2; li++) begin
            sb_q[li].delete();
            m_pass[li] = 0;
            m_fail[li] = 0;
            m_err[li]  = 1'b0;
            m_ffi[li]  = 16'hFFFF;
            m_fz[li]   = '0;
            m_fx[li]   = '0;
        end
        m_idx = 0;
    endtask

    task automatic sb_pop(input int li, input int lat);
        sb_t e;
        if (sb_q[li].size() > 0 && sb_q[li][0].stepn == cur_step - lat) begin
            e = sb_q[li].pop_front();
            if (e.ez == e.rz && e.ex == e.rx) begin
                m_pass[li]++;
            end else begin
                if (!m_err[li]) begin
                    m_ffi[li] = 16'(e.idx);
                    m_fz[li]  = e.rz;
                    m_fx[li]  = e.rx;
                end
                m_fail[li]++;
                m_err[li] = 1'b1;
            end
        end
    endtask

    // One clock: drive at the falling edge, let the rising edge happen, settle.
    task automatic step(input logic st, input logic v, input logic last,
                        input logic signed [7:0] ez, input logic signed [7:0] rz,
                        input logic signed [15:0] ex, input logic signed [15:0] rx);
        sb_t e;
        @(negedge Clk);
        for (int k = 3; k > 0; k--) begin
            hz[k] = hz[k-1];
            hx[k] = hx[k-1];
        end
        hz[0] = rz;
        hx[0] = rx;
        start      = st;
        stim_valid = v;
        stim_last  = last;
        exp_z      = ez;
        exp_x      = ex;
        dut_z1     = hz[1];
        dut_x1     = hx[1];
        dut_z3     = hz[3];
        dut_x3     = hx[3];
        if (running && v) begin
            e.stepn = cur_step;
            e.idx   = m_idx;
            e.ez = ez; e.rz = rz; e.ex = ex; e.rx = rx;
            sb_q[0].push_back(e);
            sb_q[1].push_back(e);
            m_idx++;
            if (last) running = 1'b0;
        end else if (!running && st) begin
            running = 1'b1;
            sb_reset();
        end
        sb_pop(0, 1);
        sb_pop(1, 3);
        @(posedge Clk);
        #1;
        cur_step++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'sd0, 8'sd0, 16'sd0, 16'sd0);
    endtask

    task automatic vec(input logic signed [7:0] ez, input logic signed [15:0] ex,
                       input logic signed [7:0] rz, input logic signed [15:0] rx,
                       input logic last);
        step(1'b0, 1'b1, last, ez, rz, ex, rx);
    endtask

    task automatic check_run(input string tag);
        int sp, sf;
        sp = (m_pass[0] > 3) ? 3 : m_pass[0];
        sf = (m_fail[0] > 3) ? 3 : m_fail[0];
        check_val({tag, "_l1_pass"}, 32'(pass1), 32'(m_pass[0]));
        check_val({tag, "_l1_fail"}, 32'(fail1), 32'(m_fail[0]));
        check_val({tag, "_l1_err"},  32'(err1),  32'(m_err[0]));
        check_val({tag, "_l1_ffi"},  32'(ffi1),  32'(m_ffi[0]));
        check_val({tag, "_l1_fz"},   32'(fz1),   CAP ? 32'(m_fz[0]) : 32'd0);
        check_val({tag, "_l1_fx"},   32'(fx1),   CAP ? 32'(m_fx[0]) : 32'd0);
        check_val({tag, "_l3_pass"}, 32'(pass3), 32'(m_pass[1]));
        check_val({tag, "_l3_fail"}, 32'(fail3), 32'(m_fail[1]));
        check_val({tag, "_l3_err"},  32'(err3),  32'(m_err[1]));
        check_val({tag, "_l3_ffi"},  32'(ffi3),  32'(m_ffi[1]));
        check_val({tag, "_l3_fx"},   32'(fx3),   CAP ? 32'(m_fx[1]) : 32'd0);
        check_val({tag, "_s_pass"},  32'(passs), 32'(sp));
        check_val({tag, "_s_fail"},  32'(fails), 32'(sf));
        check_val({tag, "_s_ffi"},   32'(ffis),  32'(m_ffi[0][1:0]));
        check_val({tag, "_sb_empty"}, 32'(sb_q[0].size() + sb_q[1].size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b0; start = 1'b0; stim_valid = 1'b0; stim_last = 1'b0;
        exp_z = '0; exp_x = '0; dut_z1 = '0; dut_x1 = '0; dut_z3 = '0; dut_x3 = '0;
        for (int k = 0; k < 4; k++) begin hz[k] = '0; hx[k] = '0; end
        running = 1'b0; cur_step = 0;
        sb_reset();

        repeat (3) @(posedge Clk);
        #1;
        check_val("rst_busy", 32'(busy1), 32'd0);
        check_val("rst_done", 32'(done1), 32'd0);
        check_val("rst_err",  32'(err1),  32'd0);
        check_val("rst_pass", 32'(pass1), 32'd0);
        check_val("rst_fail", 32'(fail1), 32'd0);
        check_val("rst_ffi",  32'(ffi1),  32'hFFFF);
        check_val("rst_ffi3", 32'(ffi3),  32'hFFFF);
        check_val("rst_ffis", 32'(ffis),  32'h3);
        check_val("rst_fx",   32'(fx1),   32'd0);
        @(negedge Clk);
        Rst = 1'b1;

        // stim_valid while idle is ignored
        step(1'b0, 1'b1, 1'b1, 8'sd9, 8'sd1, 16'sd99, 16'sd2);
        idle(2);
        check_val("idle_stim_pass", 32'(pass1), 32'd0);
        check_val("idle_stim_fail", 32'(fail1), 32'd0);
        check_val("idle_stim_busy", 32'(busy1), 32'd0);

        // A: single vector, a=5 b=7 c=3 -> z=15 x=35
        step(1'b1, 1'b0, 1'b0, 8'sd0, 8'sd0, 16'sd0, 16'sd0);
        check_val("a_busy", 32'(busy1), 32'd1);
        vec(8'sd15, 16'sd35, 8'sd15, 16'sd35, 1'b1);
        check_val("a_done1_t0", 32'(done1), 32'd1);
        check_val("a_done3_t0", 32'(done3), 32'd0);
        check_val("a_busy3_t0", 32'(busy3), 32'd1);
        idle(1);
        check_val("a_done3_t1", 32'(done3), 32'd0);
        idle(1);
        check_val("a_done3_t2", 32'(done3), 32'd1);
        idle(3);
        check_run("a");
        check_val("a_pass_const", 32'(pass1), 32'd1);
        check_val("a_err_const",  32'(err1),  32'd0);

        // B: one x mismatch at index 1, start pulsed mid-run
        step(1'b1, 1'b0, 1'b0, 8'sd0, 8'sd0, 16'sd0, 16'sd0);
        vec(8'sd1, 16'sd35, 8'sd1, 16'sd35, 1'b0);
        vec(8'sd2, 16'sd10, 8'sd2, 16'sd11, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'sd0, 8'sd0, 16'sd0, 16'sd0);
        check_val("b_start_ignored", 32'(busy1), 32'd1);
        vec(8'sd3, -16'sd6, 8'sd3, -16'sd6, 1'b0);
        vec(8'sd4, 16'sd0, 8'sd4, 16'sd0, 1'b1);
        idle(5);
        check_run("b");
        check_val("b_pass_const", 32'(pass1), 32'd3);
        check_val("b_fail_const", 32'(fail1), 32'd1);
        check_val("b_ffi_const",  32'(ffi1),  32'd1);
        check_val("b_fx_const",   32'(fx1),   CAP ? 32'd11 : 32'd0);

        // C: second run, 2-cycle gap between 2nd and 3rd vector
        step(1'b1, 1'b0, 1'b0, 8'sd0, 8'sd0, 16'sd0, 16'sd0);
        vec(8'sd10, 16'sd100, 8'sd10, 16'sd100, 1'b0);
        vec(-8'sd11, -16'sd100, -8'sd11, -16'sd100, 1'b0);
        idle(2);
        vec(8'sd12, 16'sd7, 8'sd12, 16'sd7, 1'b1);
        check_val("c_done3_t0", 32'(done3), 32'd0);
        idle(1);
        check_val("c_done3_t1", 32'(done3), 32'd0);
        idle(1);
        check_val("c_done3_t2", 32'(done3), 32'd1);
        idle(3);
        check_run("c");
        check_val("c_pass3_const", 32'(pass3), 32'd3);
        check_val("c_err3_const",  32'(err3),  32'd0);
        check_val("c_ffi1_const",  32'(ffi1),  32'hFFFF);

        // stim_valid in DONE is ignored and does not restart
        vec(8'sd1, 16'sd1, 8'sd2, 16'sd2, 1'b1);
        idle(4);
        check_run("c_post");
        check_val("c_post_done1", 32'(done1), 32'd1);
        check_val("c_post_done3", 32'(done3), 32'd1);

        // D: six vectors, last one mismatches; 2-bit counters saturate, index wraps
        step(1'b1, 1'b0, 1'b0, 8'sd0, 8'sd0, 16'sd0, 16'sd0);
        for (int i = 0; i < 5; i++) vec(8'(i), 16'(i * 3), 8'(i), 16'(i * 3), 1'b0);
        vec(8'sd50, 16'sd500, 8'sd51, 16'sd500, 1'b1);
        idle(5);
        check_run("d");
        check_val("d_sat_pass", 32'(passs), 32'd3);
        check_val("d_sat_ffi",  32'(ffis),  32'd1);
        check_val("d_ffi1",     32'(ffi1),  32'd5);

        // E: reset in the middle of a run
        step(1'b1, 1'b0, 1'b0, 8'sd0, 8'sd0, 16'sd0, 16'sd0);
        vec(8'sd1, 16'sd1, 8'sd1, 16'sd2, 1'b0);
        vec(8'sd3, 16'sd3, 8'sd3, 16'sd3, 1'b0);
        idle(1);
        check_val("e_pre_err",  32'(err1),  32'(m_err[0]));
        check_val("e_pre_fail", 32'(fail1), 32'(m_fail[0]));
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        check_val("e_rst_busy", 32'(busy1), 32'd0);
        check_val("e_rst_pass", 32'(pass1), 32'd0);
        check_val("e_rst_fail", 32'(fail1), 32'd0);
        check_val("e_rst_err",  32'(err1),  32'd0);
        check_val("e_rst_ffi",  32'(ffi1),  32'hFFFF);
        check_val("e_rst_ffi3", 32'(ffi3),  32'hFFFF);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        running = 1'b0;
        sb_reset();
        idle(2);
        check_val("e_post_busy", 32'(busy1), 32'd0);
        check_val("e_post_done", 32'(done1), 32'd0);
        check_val("e_post_busy3", 32'(busy3), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/result_checker.md
Name: result_checker

Overview:
- Response-side companion to the stimulus driver of the circuit1 datapath: receives the expected results for each applied vector, delays them by the DUT pipeline latency, and compares them against the DUT outputs z and x.
- Counts passes and failures, flags a sticky error and reports the index of the first mismatching vector.
- Synthesizable; sits beside circuit1 in the test harness or on-board self-test.

Parameters:
- DATAW, 8, width of z / exp_z (signed)
- PRODW, 16, width of x / exp_x (signed)
- LATENCY, 1, cycles from the stim_valid edge to the DUT result edge; legal range 1..8
- CNTW, 16, width of counters and index

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  asynchronous, active-low reset
- start  in  1  begin a new check run
- stim_valid  in  1  a vector is being applied to the DUT this cycle
- stim_last  in  1  qualifies stim_valid: final vector of the run
- exp_z  in  DATAW  expected z for this vector
- exp_x  in  PRODW  expected x for this vector
- dut_z  in  DATAW  DUT output z
- dut_x  in  PRODW  DUT output x
- busy  out  1  run in progress (RUN or DRAIN)
- done  out  1  run complete
- err  out  1  sticky: at least one mismatch in this run
- pass_cnt  out  CNTW  matching vectors
- fail_cnt  out  CNTW  mismatching vectors
- first_fail_idx  out  CNTW  index of first mismatching vector (0-based)
- fail_z  out  DATAW  dut_z captured at first mismatch (macro-dependent)
- fail_x  out  PRODW  dut_x captured at first mismatch (macro-dependent)

Behaviour:
- Reset (Rst=0, async, any state): FSM to IDLE; pipeline valids cleared.
  - All outputs 0 except first_fail_idx, which resets to all-ones (no failure).
- FSM states:
  - IDLE: start -> RUN; clear counters, err, fail_z, fail_x and vector index; set first_fail_idx to all-ones.
  - RUN: on each stim_valid, push {exp_z, exp_x, index} into a LATENCY-deep shift pipeline and increment index. stim_valid with stim_last -> DRAIN.
  - DRAIN: accept no new vectors; go to DONE on the cycle the last pipeline entry is compared (LATENCY-1 cycles after entry; if LATENCY=1, DONE directly).
  - DONE: done=1; start -> RUN with the same clearing as IDLE.
- Comparison: when the pipeline tail valid is 1, compare it against dut_z/dut_x sampled on the same edge.
  - Both fields must be equal, bit-exact signed compare.
  - Match: pass_cnt++.
  - Mismatch: fail_cnt++ and err=1. If this is the first failure of the run, latch first_fail_idx = entry index.
- Tail valid=0 (bubbles, stim_valid gaps): no compare, no count change.
- Counters saturate at 2^CNTW-1; the index wraps.
- start is ignored in RUN and DRAIN; stim_valid is ignored in IDLE, DRAIN and DONE.
- busy=1 exactly in RUN and DRAIN; done=1 exactly in DONE. Outputs are registered.
- In DONE, pass_cnt+fail_cnt equals the number of accepted vectors (absent saturation).

Optional Feature:
- Macro RESULT_CHECKER_CAPTURE_EN.
- Defined: on the first mismatch of a run, fail_z/fail_x latch dut_z/dut_x and hold until the next start or reset.
- Undefined: no capture registers are built; fail_z and fail_x are tied to 0.
- All other behaviour is identical in both builds.

Test Plan:
- Reset mid-RUN (Rst low for 3 cycles) -> IDLE immediately; counters 0; first_fail_idx=16'hFFFF; busy=0.
- LATENCY=1; start; one vector a=5,b=7,c=3, exp_z=15, exp_x=35, stim_last=1; DUT returns 15/35 one cycle later -> pass_cnt=1, fail_cnt=0, err=0, done=1.
- Four vectors with exp_x=35,10,-6,0; DUT returns x=35,11,-6,0 -> pass_cnt=3, fail_cnt=1, err=1, first_fail_idx=1, fail_x=11 (macro defined) or 0 (undefined).
- LATENCY=3; vectors with a 2-cycle stim_valid gap between the 2nd and 3rd; DUT responses shifted 3 cycles -> pass_cnt=3; done asserts exactly 2 cycles after the stim_last cycle.
- stim_valid pulses in IDLE and DONE, and start pulsed during RUN -> ignored; counts unchanged; run does not restart.
- Second run after DONE with all matches -> err=0, counts reflect only the second run.
